display7seg_mux: RTL and testbench

DISPLAY7SEG_MUX -- requirements
Module: display7seg_mux

---
 rtl/display7seg_mux.sv | 88 ++++++++
 tb/tb_display7seg_mux.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/display7seg_mux.sv
// Multiplexed BCD 7-segment driver: shadow-registered digits scanned one slot at a time.
// Optional leading-zero blanking is compiled in with `define ZERO_SUPPRESS_EN.
module display7seg_dec (
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = 7'b1111111;
    case (i_bcd)
      4'd0: o_seg = 7'b0000001;
      4'd1: o_seg = 7'b1001111;
      4'd2: o_seg = 7'b0010010;
      4'd3: o_seg = 7'b0000110;
      4'd4: o_seg = 7'b1001100;
      4'd5: o_seg = 7'b0100100;
      4'd6: o_seg = 7'b0100000;
      4'd7: o_seg = 7'b0001111;
      4'd8: o_seg = 7'b0000000;
      4'd9: o_seg = 7'b0000100;
      default: o_seg = 7'b1111111;
    endcase
  end
endmodule

module display7seg_mux #(
  parameter int NUM_DIGITOS = 4,
  parameter int DIV_REFRESH = 50000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [4*NUM_DIGITOS-1:0] entrada,
  input  logic                     carga,
  input  logic                     habilita,
  output logic [6:0]               saida,
  output logic [NUM_DIGITOS-1:0]   anodo
);
  localparam int IW = (NUM_DIGITOS > 1) ? $clog2(NUM_DIGITOS) : 1;
  localparam int CW = $clog2(DIV_REFRESH);

  logic [4*NUM_DIGITOS-1:0]        r_shadow;
  logic [CW-1:0]                   r_cont;
  logic [IW-1:0]                   r_idx;
  logic [NUM_DIGITOS-1:0][6:0]     w_seg;
  logic [NUM_DIGITOS-1:0]          w_sup;
  logic                            w_dark;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_cont   <= '0;
      r_idx    <= '0;
    end else begin
      if (carga) r_shadow <= entrada;
      if (!habilita) begin
        r_cont <= '0;
        r_idx  <= '0;
      end else if (r_cont == CW'(DIV_REFRESH-1)) begin
        r_cont <= '0;
        r_idx  <= (r_idx == IW'(NUM_DIGITOS-1)) ? '0 : r_idx + IW'(1);
      end else begin
        r_cont <= r_cont + CW'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_DIGITOS; g++) begin : g_dec
    display7seg_dec u_dec (.i_bcd(r_shadow[4*g +: 4]), .o_seg(w_seg[g]));
  end

  // w_sup[k]: digit k and everything above it are zero; digit 0 never blanks
  always_comb begin
    w_sup = '0;
`ifdef ZERO_SUPPRESS_EN
    begin
      logic w_all;
      w_all = 1'b1;
      for (int k = NUM_DIGITOS-1; k > 0; k--) begin
        w_all    = w_all && (r_shadow[4*k +: 4] == 4'd0);
        w_sup[k] = w_all;
      end
    end
`endif
  end

  assign w_dark = !habilita || (r_cont == '0);
  assign anodo  = w_dark ? '1 : ~(NUM_DIGITOS'(1) << r_idx);
  assign saida  = (w_dark || w_sup[r_idx]) ? 7'b1111111 : w_seg[r_idx];
endmodule

// File: tb/tb_display7seg_mux.sv
// Randomized bench for display7seg_mux against a scan-position reference model.
module tb_display7seg_mux;
  localparam int N = 4, D = 4, P = N*D;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [15:0] entrada = '0;
  logic        carga = 1'b0, habilita = 1'b0;
  logic [6:0]  saida;
  logic [3:0]  anodo;

  int checks = 0, errors = 0;
  logic [3:0] m_dig [N];
  int         m_t;
  logic [6:0] seg_tab [16];

  always #5 clk = ~clk;

  display7seg_mux #(.NUM_DIGITOS(N), .DIV_REFRESH(D)) dut (
    .clk(clk), .rst_n(rst_n), .entrada(entrada), .carga(carga),
    .habilita(habilita), .saida(saida), .anodo(anodo)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scan position m_t counts cycles into the full period; slot/phase derive from it.
  function automatic logic [3:0] exp_an();
    int slot;
    slot = m_t / D;
    if (!habilita || (m_t % D) == 0) return 4'hF;
    return ~(4'b0001 << slot);
  endfunction

  function automatic logic [6:0] exp_seg();
    int  slot;
    bit  blank;
    slot = m_t / D;
    if (exp_an() == 4'hF) return 7'h7F;
    blank = 1'b0;
`ifdef ZERO_SUPPRESS_EN
    if (slot > 0) begin
      blank = 1'b1;
      for (int k = slot; k < N; k++) if (m_dig[k] != 4'd0) blank = 1'b0;
    end
`endif
    return blank ? 7'h7F : seg_tab[m_dig[slot]];
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      for (int k = 0; k < N; k++) m_dig[k] = 4'd0;
      m_t = 0;
    end else begin
      if (carga) for (int k = 0; k < N; k++) m_dig[k] = entrada[4*k +: 4];
      m_t = habilita ? (m_t + 1) % P : 0;
    end
  endtask

  task automatic check_now(input string tag);
    chk({tag, "_an"}, 16'(anodo), 16'(exp_an()));
    chk({tag, "_sg"}, 16'(saida), 16'(exp_seg()));
  endtask

  task automatic tick(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_now(tag);
    end
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_an"}, 16'(anodo), 16'hF);
    chk({tag, "_sg"}, 16'(saida), 16'h7F);
    tick(1, tag);
    rst_n = 1'b1;
  endtask

  initial begin
    seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    for (int k = 0; k < N; k++) m_dig[k] = 4'd0;
    m_t = 0;
    #1;
    chk("rst_an", 16'(anodo), 16'hF);
    chk("rst_sg", 16'(saida), 16'h7F);
    tick(2, "rst");

    rst_n = 1'b1; habilita = 1'b1; entrada = 16'h1234; carga = 1'b1;
    tick(1, "load");
    chk("first_an", 16'(anodo), 16'hE);
    chk("first_sg", 16'(saida), 16'(7'b1001100));
    carga = 1'b0;
    tick(2*P, "load");

    entrada = 16'h9999;
    tick(2*P, "hold");

    entrada = 16'h12A4; carga = 1'b1;
    tick(1, "inval");
    carga = 1'b0;
    tick(P, "inval");

    entrada = 16'h0070; carga = 1'b1;
    tick(1, "zsup");
    carga = 1'b0;
    tick(P, "zsup");

    // reset mid-scan at slot 2
    entrada = 16'h1234; carga = 1'b1;
    for (int i = 0; i < P && (m_t / D) != 2; i++) tick(1, "seek");
    async_reset("mrst");
    tick(1, "mrst");
    chk("mrst_first_an", 16'(anodo), 16'hE);
    carga = 1'b0;
    tick(P, "mrst");

    // disable at slot 3, mid-slot
    for (int i = 0; i < P && !((m_t / D) == 3 && (m_t % D) == 2); i++) tick(1, "seek");
    habilita = 1'b0;
    #1 check_now("dis");
    chk("dis_an", 16'(anodo), 16'hF);
    tick(3, "dis");
    habilita = 1'b1;
    tick(P, "reen");

    // load coinciding with a slot wrap
    for (int i = 0; i < P && (m_t % D) != D-1; i++) tick(1, "seek");
    entrada = 16'h5678; carga = 1'b1;
    tick(1, "wrap");
    carga = 1'b0;
    tick(P, "wrap");

    for (int i = 0; i < 1500; i++) begin
      entrada  = 16'($urandom);
      carga    = ($urandom % 8) == 0;
      habilita = ($urandom % 20) != 0;
      if (($urandom % 150) == 0) async_reset("rrst");
      tick(1, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
